// File: rtl/video_capture.sv
// video_capture: samples an RGB888 pixel stream framed by vsyn/hsyn, converts
// each captured pixel to an RGB332 byte, packs eight bytes per 64-bit word
// (byte 0 first) and writes the words into framebuffer memory through a
// small write buffer using the host write path (addr/data/byte-enable).
module video_capture #(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = 12
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          arm,
   input  logic          abort,
   input  logic          vsyn,
   input  logic          hsyn,
   input  logic          pix_valid,
   input  logic [7:0]    red,
   input  logic [7:0]    green,
   input  logic [7:0]    blue,
   input  logic [CW-1:0] cfg_hstart,
   input  logic [CW-1:0] cfg_width,
   input  logic [CW-1:0] cfg_height,
   input  logic [7:0]    cfg_stride,
   input  logic [15:0]   cfg_base,
   output logic          wr_en,
   input  logic          wr_ready,
   output logic [19:0]   wr_addr,
   output logic [63:0]   wr_data,
   output logic [7:0]    wr_we,
   output logic          busy,
   output logic          done,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   // Byte enables for a partial word holding n bytes: (1<<n)-1.
   function automatic logic [7:0] we_mask(input logic [2:0] n);
      logic [8:0] m;
      m = (9'd1 << n) - 9'd1;
      return m[7:0];
   endfunction

   // RGB888 -> RGB332 palette index.
   function automatic logic [7:0] to_rgb332(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
      return {r[7:5], g[7:5], b[7:6]};
   endfunction

   state_t        state_r;
   logic          vsyn_r, vsyn_d_r, hsyn_r, hsyn_d_r;
   logic          vsyn_edge_s, hsyn_edge_s;
   logic [CW-1:0] cfg_hstart_r, cfg_width_r, cfg_height_r;
   logic [7:0]    cfg_stride_r;
   logic [15:0]   cfg_base_r;
   logic [CW-1:0] col_r, line_r;
   logic [2:0]    pack_r;
   logic [15:0]   widx_r, lbase_r;
   logic [63:0]   asm_r;
   logic          flush_pend_r, drain_pend_r;
   logic          slot_vld_r;
   logic [63:0]   slot_data_r;
   logic [15:0]   slot_addr_r;
   logic [7:0]    slot_we_r;
   logic          done_r;

   // pixel-path helpers (a pending line end restarts the line before the pixel)
   logic [CW-1:0] col_base_s, line_inc_s;
   logic [2:0]    pack_base_s;
   logic [15:0]   widx_base_s, lbase_base_s;
   logic [63:0]   asm_base_s, asm_pix_s;
   logic          in_win_s, last_line_s;

   // write buffer
   logic [63:0]   mem_data_r [FIFO_DEPTH];
   logic [15:0]   mem_addr_r [FIFO_DEPTH];
   logic [7:0]    mem_we_r   [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_n_s, wr_ptr_n_s;
   logic [AW:0]   cnt_r, cnt_n_s;
   logic          pop_s, accept_s, drop_s, clr_flags_s;
   logic          head_vld_s;
   logic [63:0]   head_data_s;
   logic [15:0]   head_addr_s;
   logic [7:0]    head_we_s;
   logic          wr_en_r;
   logic [19:0]   wr_addr_r;
   logic [63:0]   wr_data_r;
   logic [7:0]    wr_we_r;
   logic          overflow_r;

   assign vsyn_edge_s = vsyn_r & ~vsyn_d_r;
   assign hsyn_edge_s = hsyn_r & ~hsyn_d_r;
   assign clr_flags_s = (state_r == ST_IDLE) & arm & ~abort;

   // Register the sync inputs and keep the previous sample for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vsyn_r   <= 1'b0;
         vsyn_d_r <= 1'b0;
         hsyn_r   <= 1'b0;
         hsyn_d_r <= 1'b0;
      end else begin
         vsyn_r   <= vsyn;
         vsyn_d_r <= vsyn_r;
         hsyn_r   <= hsyn;
         hsyn_d_r <= hsyn_r;
      end
   end

   // Column/pack position and captured-window test for the current pixel.
   always_comb begin
      col_base_s   = flush_pend_r ? {CW{1'b0}} : col_r;
      pack_base_s  = flush_pend_r ? 3'd0 : pack_r;
      widx_base_s  = flush_pend_r ? 16'd0 : widx_r;
      lbase_base_s = flush_pend_r ? (lbase_r + {8'd0, cfg_stride_r}) : lbase_r;
      asm_base_s   = flush_pend_r ? 64'd0 : asm_r;
      line_inc_s   = line_r + {{(CW-1){1'b0}}, 1'b1};
      last_line_s  = (line_inc_s == cfg_height_r);
      in_win_s     = (col_base_s >= cfg_hstart_r) &&
                     ({1'b0, col_base_s} < ({1'b0, cfg_hstart_r} + {1'b0, cfg_width_r}));
      asm_pix_s    = asm_base_s;
      asm_pix_s[{pack_base_s, 3'b000} +: 8] = to_rgb332(red, green, blue);
   end

   // Capture FSM: config sampling, pixel packing, line ends and word pushes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         cfg_hstart_r <= {CW{1'b0}};
         cfg_width_r  <= {CW{1'b0}};
         cfg_height_r <= {CW{1'b0}};
         cfg_stride_r <= 8'd0;
         cfg_base_r   <= 16'd0;
         col_r        <= {CW{1'b0}};
         line_r       <= {CW{1'b0}};
         pack_r       <= 3'd0;
         widx_r       <= 16'd0;
         lbase_r      <= 16'd0;
         asm_r        <= 64'd0;
         flush_pend_r <= 1'b0;
         drain_pend_r <= 1'b0;
         slot_vld_r   <= 1'b0;
         slot_data_r  <= 64'd0;
         slot_addr_r  <= 16'd0;
         slot_we_r    <= 8'd0;
         done_r       <= 1'b0;
      end else begin
         slot_vld_r <= 1'b0;
         if (abort) begin
            state_r      <= ST_IDLE;
            flush_pend_r <= 1'b0;
            drain_pend_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (arm) begin
                     cfg_hstart_r <= cfg_hstart;
                     cfg_width_r  <= cfg_width;
                     cfg_height_r <= cfg_height;
                     cfg_stride_r <= cfg_stride;
                     cfg_base_r   <= cfg_base;
                     done_r       <= 1'b0;
                     state_r      <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (vsyn_edge_s) begin
                     col_r        <= {CW{1'b0}};
                     line_r       <= {CW{1'b0}};
                     pack_r       <= 3'd0;
                     widx_r       <= 16'd0;
                     lbase_r      <= cfg_base_r;
                     asm_r        <= 64'd0;
                     flush_pend_r <= 1'b0;
                     drain_pend_r <= 1'b0;
                     state_r      <= ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  if (flush_pend_r) begin
                     flush_pend_r <= 1'b0;
                     drain_pend_r <= 1'b0;
                     if (pack_r != 3'd0) begin
                        slot_vld_r  <= 1'b1;
                        slot_data_r <= asm_r;
                        slot_addr_r <= lbase_r + widx_r;
                        slot_we_r   <= we_mask(pack_r);
                     end
                     line_r  <= line_inc_s;
                     col_r   <= {CW{1'b0}};
                     pack_r  <= 3'd0;
                     widx_r  <= 16'd0;
                     lbase_r <= lbase_r + {8'd0, cfg_stride_r};
                     asm_r   <= 64'd0;
                  end
                  if (flush_pend_r && (drain_pend_r || last_line_s)) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     if (pix_valid) begin
                        col_r <= col_base_s + {{(CW-1){1'b0}}, 1'b1};
                        if (in_win_s) begin
                           if (pack_base_s == 3'd7) begin
                              slot_vld_r  <= 1'b1;
                              slot_data_r <= asm_pix_s;
                              slot_addr_r <= lbase_base_s + widx_base_s;
                              slot_we_r   <= 8'hFF;
                              pack_r      <= 3'd0;
                              widx_r      <= widx_base_s + 16'd1;
                              asm_r       <= 64'd0;
                           end else begin
                              asm_r  <= asm_pix_s;
                              pack_r <= pack_base_s + 3'd1;
                           end
                        end
                     end
                     if (hsyn_edge_s || vsyn_edge_s) begin
                        flush_pend_r <= 1'b1;
                        drain_pend_r <= vsyn_edge_s;
                     end
                  end
               end
               ST_DRAIN: begin
                  if ((cnt_r == {(AW+1){1'b0}}) && !slot_vld_r) begin
                     state_r <= ST_IDLE;
                     done_r  <= 1'b1;
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   // Write-buffer next state and the entry that will sit at its head.
   always_comb begin
      pop_s      = wr_en_r & wr_ready;
      accept_s   = slot_vld_r & ((cnt_r != FULL_CNT) | pop_s);
      drop_s     = slot_vld_r & ~accept_s;
      rd_ptr_n_s = rd_ptr_r + AW'(pop_s);
      wr_ptr_n_s = wr_ptr_r + AW'(accept_s);
      cnt_n_s    = cnt_r + (AW+1)'(accept_s) - (AW+1)'(pop_s);
      head_vld_s = (cnt_n_s != {(AW+1){1'b0}});
      if (!head_vld_s) begin
         head_data_s = 64'd0;
         head_addr_s = 16'd0;
         head_we_s   = 8'd0;
      end else if (accept_s && (wr_ptr_r == rd_ptr_n_s)) begin
         head_data_s = slot_data_r;
         head_addr_s = slot_addr_r;
         head_we_s   = slot_we_r;
      end else begin
         head_data_s = mem_data_r[rd_ptr_n_s];
         head_addr_s = mem_addr_r[rd_ptr_n_s];
         head_we_s   = mem_we_r[rd_ptr_n_s];
      end
   end

   // Write-buffer pointers, registered write-port outputs and overflow flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         cnt_r      <= {(AW+1){1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= 20'd0;
         wr_data_r  <= 64'd0;
         wr_we_r    <= 8'd0;
         overflow_r <= 1'b0;
      end else if (abort) begin
         rd_ptr_r  <= {AW{1'b0}};
         wr_ptr_r  <= {AW{1'b0}};
         cnt_r     <= {(AW+1){1'b0}};
         wr_en_r   <= 1'b0;
         wr_addr_r <= 20'd0;
         wr_data_r <= 64'd0;
         wr_we_r   <= 8'd0;
      end else begin
         rd_ptr_r  <= rd_ptr_n_s;
         wr_ptr_r  <= wr_ptr_n_s;
         cnt_r     <= cnt_n_s;
         wr_en_r   <= head_vld_s;
         wr_addr_r <= head_vld_s ? {1'b1, head_addr_s, 3'b000} : 20'd0;
         wr_data_r <= head_data_s;
         wr_we_r   <= head_we_s;
         if (clr_flags_s) begin
            overflow_r <= 1'b0;
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Write-buffer storage; contents are don't-care while an entry is free.
   always_ff @(posedge clk_i) begin
      if (accept_s && !abort) begin
         mem_data_r[wr_ptr_r] <= slot_data_r;
         mem_addr_r[wr_ptr_r] <= slot_addr_r;
         mem_we_r[wr_ptr_r]   <= slot_we_r;
      end
   end

   assign wr_en    = wr_en_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;
   assign wr_we    = wr_we_r;
   assign busy     = (state_r != ST_IDLE) || (cnt_r != {(AW+1){1'b0}});
   assign done     = done_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: frames are armed, pixels and syncs are
// driven 2 ns after each rising edge, and every accepted write is recorded
// on the falling edge for comparison against hand-computed words.
module tb_video_capture;
   localparam int CW = 12;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          arm = 1'b0, abort = 1'b0, vsyn = 1'b0, hsyn = 1'b0, pix_valid = 1'b0;
   logic [7:0]    red = 8'd0, green = 8'd0, blue = 8'd0;
   logic [CW-1:0] cfg_hstart = '0, cfg_width = '0, cfg_height = '0;
   logic [7:0]    cfg_stride = 8'd0;
   logic [15:0]   cfg_base = 16'd0;
   logic          wr_en, wr_ready = 1'b0, busy, done, overflow;
   logic [19:0]   wr_addr;
   logic [63:0]   wr_data;
   logic [7:0]    wr_we;

   int n_pass = 0;
   int n_total = 0;
   logic [19:0] q_addr[$];
   logic [63:0] q_data[$];
   logic [7:0]  q_we[$];

   video_capture #(.FIFO_DEPTH(4), .CW(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .arm(arm), .abort(abort), .vsyn(vsyn), .hsyn(hsyn),
      .pix_valid(pix_valid), .red(red), .green(green), .blue(blue),
      .cfg_hstart(cfg_hstart), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_stride(cfg_stride), .cfg_base(cfg_base),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_we(wr_we), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk_i = ~clk_i;

   // record every write that will be accepted on the coming rising edge
   always @(negedge clk_i) begin
      if (wr_en && wr_ready) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
         q_we.push_back(wr_we);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_we.delete();
   endtask

   task automatic start_frame(input logic [CW-1:0] hs, input logic [CW-1:0] wd,
                              input logic [CW-1:0] ht, input logic [7:0] st,
                              input logic [15:0] bs);
      cfg_hstart = hs; cfg_width = wd; cfg_height = ht; cfg_stride = st; cfg_base = bs;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      cfg_hstart = ~hs; cfg_width = ~wd; cfg_height = ~ht; cfg_stride = ~st; cfg_base = ~bs;
      vsyn = 1'b1;
      tick();
      tick();
      vsyn = 1'b0;
      tick();
      tick();
   endtask

   task automatic pixels(input int n, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1; red = r; green = g; blue = b;
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic line_end();
      hsyn = 1'b1;
      tick();
      tick();
      hsyn = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      chk(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      // ---- reset state ----
      tick(); tick(); tick();
      rst_i = 1'b0;
      tick();
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_wr_we", 64'(wr_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);

      // ---- basic line: 16 red pixels, two full words ----
      wr_ready = 1'b1;
      clear_log();
      start_frame(12'd0, 12'd16, 12'd1, 8'd32, 16'h0100);
      chk("basic_busy", 64'(busy), 64'd1);
      pixels(8, 8'hE0, 8'h00, 8'h00);
      chk("basic_lat_before", 64'(wr_en), 64'd0);
      tick();
      chk("basic_lat_wr_en", 64'(wr_en), 64'd1);
      chk("basic_lat_addr", 64'(wr_addr), 64'h80800);
      pixels(8, 8'hE0, 8'h00, 8'h00);
      line_end();
      wait_idle("basic_idle");
      chk("basic_count", 64'(q_addr.size()), 64'd2);
      chk("basic_addr0", 64'(q_addr[0]), 64'h80800);
      chk("basic_addr1", 64'(q_addr[1]), 64'h80808);
      chk("basic_data0", q_data[0], 64'hE0E0_E0E0_E0E0_E0E0);
      chk("basic_data1", q_data[1], 64'hE0E0_E0E0_E0E0_E0E0);
      chk("basic_we0", 64'(q_we[0]), 64'hFF);
      chk("basic_we1", 64'(q_we[1]), 64'hFF);
      chk("basic_done", 64'(done), 64'd1);

      // ---- partial word with hstart=3, width=5 ----
      clear_log();
      start_frame(12'd3, 12'd5, 12'd1, 8'd32, 16'h0200);
      chk("partial_done_cleared", 64'(done), 64'd0);
      pixels(10, 8'h00, 8'h00, 8'hC0);
      line_end();
      wait_idle("partial_idle");
      chk("partial_count", 64'(q_addr.size()), 64'd1);
      chk("partial_addr", 64'(q_addr[0]), 64'h81000);
      chk("partial_data", q_data[0], 64'h0000_0003_0303_0303);
      chk("partial_we", 64'(q_we[0]), 64'h1F);
      chk("partial_done", 64'(done), 64'd1);

      // ---- stride across three lines ----
      clear_log();
      start_frame(12'd0, 12'd8, 12'd3, 8'd32, 16'h0000);
      pixels(8, 8'hE0, 8'h00, 8'h00);
      line_end();
      pixels(8, 8'h00, 8'hFF, 8'h00);
      line_end();
      pixels(8, 8'h00, 8'h00, 8'hFF);
      tick(); tick(); tick();
      chk("stride_count_pre", 64'(q_addr.size()), 64'd3);
      chk("stride_done_pre", 64'(done), 64'd0);
      line_end();
      wait_idle("stride_idle");
      chk("stride_addr0", 64'(q_addr[0]), 64'h80000);
      chk("stride_addr1", 64'(q_addr[1]), 64'h80100);
      chk("stride_addr2", 64'(q_addr[2]), 64'h80200);
      chk("stride_data0", q_data[0], 64'hE0E0_E0E0_E0E0_E0E0);
      chk("stride_data1", q_data[1], 64'h1C1C_1C1C_1C1C_1C1C);
      chk("stride_data2", q_data[2], 64'h0303_0303_0303_0303);
      chk("stride_done", 64'(done), 64'd1);

      // ---- backpressure: 6 words into a 4-entry buffer ----
      clear_log();
      wr_ready = 1'b0;
      start_frame(12'd0, 12'd48, 12'd1, 8'd32, 16'h0300);
      for (int w = 0; w < 6; w++) begin
         pixels(8, 8'((w + 1) << 5), 8'h00, 8'h00);
      end
      tick(); tick(); tick();
      chk("bp_head_en", 64'(wr_en), 64'd1);
      chk("bp_head_addr", 64'(wr_addr), 64'h81800);
      chk("bp_head_data", wr_data, 64'h2020_2020_2020_2020);
      chk("bp_overflow", 64'(overflow), 64'd1);
      line_end();
      tick(); tick(); tick();
      chk("bp_head_addr_hold", 64'(wr_addr), 64'h81800);
      chk("bp_head_we_hold", 64'(wr_we), 64'hFF);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_done_pre", 64'(done), 64'd0);
      wr_ready = 1'b1;
      wait_idle("bp_idle");
      chk("bp_count", 64'(q_addr.size()), 64'd4);
      chk("bp_addr3", 64'(q_addr[3]), 64'h81818);
      chk("bp_data0", q_data[0], 64'h2020_2020_2020_2020);
      chk("bp_data1", q_data[1], 64'h4040_4040_4040_4040);
      chk("bp_data2", q_data[2], 64'h6060_6060_6060_6060);
      chk("bp_data3", q_data[3], 64'h8080_8080_8080_8080);
      chk("bp_done", 64'(done), 64'd1);

      // ---- abort with two words queued ----
      clear_log();
      wr_ready = 1'b0;
      start_frame(12'd0, 12'd64, 12'd1, 8'd32, 16'h0400);
      chk("abort_arm_clears_ovf", 64'(overflow), 64'd0);
      pixels(16, 8'hE0, 8'h00, 8'h00);
      tick(); tick(); tick();
      chk("abort_pre_en", 64'(wr_en), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_wr_en", 64'(wr_en), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      wr_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("abort_no_writes", 64'(q_addr.size()), 64'd0);
      start_frame(12'd0, 12'd8, 12'd1, 8'd32, 16'h0500);
      pixels(8, 8'h00, 8'hE0, 8'h00);
      line_end();
      wait_idle("abort_restart_idle");
      chk("abort_restart_count", 64'(q_addr.size()), 64'd1);
      chk("abort_restart_addr", 64'(q_addr[0]), 64'h82800);
      chk("abort_restart_data", q_data[0], 64'h1C1C_1C1C_1C1C_1C1C);
      chk("abort_restart_ovf", 64'(overflow), 64'd0);

      // ---- asynchronous reset mid-capture ----
      clear_log();
      wr_ready = 1'b0;
      start_frame(12'd0, 12'd16, 12'd1, 8'd32, 16'h0700);
      pixels(8, 8'hE0, 8'h00, 8'h00);
      tick(); tick();
      chk("arst_pre_en", 64'(wr_en), 64'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("arst_wr_en", 64'(wr_en), 64'd0);
      chk("arst_wr_addr", 64'(wr_addr), 64'd0);
      chk("arst_wr_data", wr_data, 64'd0);
      chk("arst_wr_we", 64'(wr_we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      tick();
      rst_i = 1'b0;
      tick();
      clear_log();
      wr_ready = 1'b1;
      start_frame(12'd0, 12'd8, 12'd1, 8'd32, 16'h0700);
      pixels(8, 8'h00, 8'h00, 8'hFF);
      line_end();
      wait_idle("arst_next_idle");
      chk("arst_next_count", 64'(q_addr.size()), 64'd1);
      chk("arst_next_addr", 64'(q_addr[0]), 64'h83800);
      chk("arst_next_data", q_data[0], 64'h0303_0303_0303_0303);
      chk("arst_next_we", 64'(q_we[0]), 64'hFF);
      chk("arst_next_done", 64'(done), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
